// File: rtl/switch_debouncer_pkg.sv
// Shared constants and helpers for the switch debouncer.
package switch_debouncer_pkg;

  // 50 MHz clock: 50000 cycles = 1 ms of required stability.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

  // Short window so simulations finish quickly.
  localparam int SIM_DEBOUNCE_CYCLES = 4;

  // Width of a counter that must hold values up to 'cycles'.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/switch_debouncer_channel.sv
// Single-bit debouncer.
// Contains a two-flop synchroniser, a stability counter, and registered
// rise/fall pulses. The channel is PENDING whenever the synchronised level
// differs from the accepted level. It is STABLE otherwise, and that state
// needs no register of its own.
module switch_debouncer_channel
  import switch_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             clean_q;
  logic             clean_d;
  logic             rise_q;
  logic             rise_d;
  logic             fall_q;
  logic             fall_d;

  // Two-flop synchroniser; only sync2_q feeds the decision logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level once it has differed for DEBOUNCE_CYCLES edges.
  // Any return to the accepted level clears the count.
  always_comb begin
    cnt_d   = '0;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync2_q != clean_q) begin
      if (cnt_q == CNT_LAST) begin
        clean_d = sync2_q;
        rise_d  = sync2_q;
        fall_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter, accepted level and pulses are registered together, so each
  // pulse lines up with the first cycle of the new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean_o = clean_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/switch_debouncer.sv
// Multi-channel switch conditioner.
// Each raw input bit gets its own independent synchroniser and debouncer.
// There is no coupling between channels.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  // One debounce channel per input bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    switch_debouncer_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (raw_in[i]),
      .clean_o(clean_out[i]),
      .rise_o (rise_pulse[i]),
      .fall_o (fall_pulse[i])
    );
  end

endmodule
